// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Contents:
//   mul_state_t  - controller state encoding (IDLE, CALC, FIX, DONE)
//   MUL_WIDTH    - default operand width of the eBPF datapath
//   cnt_width()  - bits needed to hold the CALC iteration count
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int MUL_WIDTH = 64;

  // The counter is loaded with width/bpc and counts down to 1, so it must
  // be able to represent width/bpc itself.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step of the multiplier.
// Ports:
//   acc      in  2*WIDTH         running partial product
//   mcand    in  2*WIDTH         multiplicand, already aligned to this step
//   mbits    in  BITS_PER_CYCLE  low multiplier bits retired this step
//   acc_next out 2*WIDTH         acc plus the selected shifted multiplicands
module mul_step #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [BITS_PER_CYCLE-1:0] mbits,
  output logic [2*WIDTH-1:0]        acc_next
);

  logic [2*WIDTH-1:0] sum;

  // Multiplier bit i weights the multiplicand by 2^i within this step.
  // Operands are magnitudes bounded by 2^(WIDTH-1) .. 2^WIDTH-1, so the
  // 2*WIDTH-bit sum cannot wrap.
  always_comb begin
    sum = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mbits[i]) begin
        sum = sum + (mcand << i);
      end
    end
  end

  assign acc_next = sum;

endmodule

// File: rtl/mul_64bit_seq.sv
// Multi-cycle shift-add WIDTH x WIDTH multiplier with a 2*WIDTH product.
// Signed operation multiplies magnitudes and negates the result when the
// operand signs differ. One operation in flight at a time.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake; a, b, signed_mode sampled on accept
//   out_valid/out_ready  response handshake; y_lo/y_hi hold the product
//   y_lo         product bits [WIDTH-1:0]
//   y_hi         product bits [2*WIDTH-1:WIDTH]
module mul_64bit_seq
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_lo,
  output logic [WIDTH-1:0] y_hi
);

  localparam int CNT_W = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam int N_OPS = WIDTH / BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_OPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_t           state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 sign;
  logic [WIDTH-1:0]     y_lo_r;
  logic [WIDTH-1:0]     y_hi_r;
  logic [2*WIDTH-1:0]   result;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  // Magnitude as an unsigned value; -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] abs_op(input logic signed [WIDTH-1:0] v,
                                              input logic                    sm);
    return (sm && (v < 0)) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] v,
                                                  input logic               neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbits    (mplier[BITS_PER_CYCLE-1:0]),
    .acc_next (acc_nxt)
  );

  assign result = neg_prod(acc, sign);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      y_lo_r <= '0;
      y_hi_r <= '0;
    end else begin
      unique case (state)
        // Accept: capture magnitudes and the product sign.
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, abs_op(a_s, signed_mode)};
            mplier <= abs_op(b_s, signed_mode);
            sign   <= signed_mode & ((a_s < 0) ^ (b_s < 0));
            acc    <= '0;
            cnt    <= CNT_LOAD;
            state  <= CALC;
          end
        end
        // Iterate: retire BITS_PER_CYCLE multiplier bits per edge.
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= FIX;
          end
        end
        // Sign fix-up and result load.
        FIX: begin
          acc    <= result;
          y_lo_r <= result[WIDTH-1:0];
          y_hi_r <= result[2*WIDTH-1:WIDTH];
          state  <= DONE;
        end
        // Hold the product until the consumer takes it.
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y_lo      = y_lo_r;
  assign y_hi      = y_hi_r;

endmodule

// File: tb/tb_mul_64bit_seq.sv
module tb_mul_64bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        signed_mode;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [63:0] y_lo1, y_hi1;
  logic        in_ready4, out_valid4;
  logic [63:0] y_lo4, y_hi4;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  typedef struct {
    logic [127:0] p;
    longint       acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_64bit_seq #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .y_lo(y_lo1), .y_hi(y_hi1)
  );

  mul_64bit_seq #(.WIDTH(64), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid4),
    .out_ready(out_ready), .y_lo(y_lo4), .y_hi(y_hi4)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: full-precision product of the operands as integers.
  function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y,
                                            input logic sm);
    logic signed [127:0] sx, sy;
    logic [127:0] ux, uy;
    if (sm) begin
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
    end
    ux = {64'd0, x};
    uy = {64'd0, y};
    return ux * uy;
  endfunction

  // Monitors: compare when a product appears on each DUT.
  logic pv1 = 1'b0, pv4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid1 && !pv1) begin
      if (q1.size() == 0) chk("bpc1_unexpected_result", 1, 0);
      else begin
        e = q1.pop_front();
        chk("bpc1_latency", 128'(cyc - e.acc), 128'd65);
        chk("bpc1_product", {y_hi1, y_lo1}, e.p);
      end
    end
    pv1 = out_valid1;
  end
  always @(negedge clk) begin
    exp_t e;
    if (out_valid4 && !pv4) begin
      if (q4.size() == 0) chk("bpc4_unexpected_result", 1, 0);
      else begin
        e = q4.pop_front();
        chk("bpc4_latency", 128'(cyc - e.acc), 128'd17);
        chk("bpc4_product", {y_hi4, y_lo4}, e.p);
      end
    end
    pv4 = out_valid4;
  end

  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic sm,
                       output longint acc_cyc);
    bit ok = 0;
    exp_t e;
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (in_ready1 && in_ready4) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("issue_timeout", 0, 1);
      in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    e.p = ref_prod(av, bv, sm);
    e.acc = cyc;
    q1.push_back(e);
    q4.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    bit ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (q1.size() == 0 && q4.size() == 0 && in_ready1 && in_ready4) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_out1(output bit ok);
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (out_valid1) begin ok = 1; break; end
    end
    if (!ok) chk("wait_out_timeout", 0, 1);
  endtask

  initial begin
    longint ac, hs;
    bit ok;
    int bad;
    logic [63:0] lo1, hi1, lo4, hi4;
    logic [63:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {in_ready1, in_ready4}, 2'b11);
    chk("reset_out_valid", {out_valid1, out_valid4}, 2'b00);
    chk("reset_y_bpc1", {y_hi1, y_lo1}, 128'd0);
    chk("reset_y_bpc4", {y_hi4, y_lo4}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // 3*5 with in_ready watched until the result appears.
    issue(64'd3, 64'd5, 1'b0, ac);
    bad = 0;
    for (int t = 0; t < 300; t++) begin
      if (out_valid1) break;
      if (in_ready1) bad++;
      @(negedge clk);
    end
    chk("busy_in_ready_low", 128'(bad), 128'd0);
    chk("small_product_value", {y_hi1, y_lo1}, 128'd15);
    drain();

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, ac); drain();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, ac); drain();
    issue(64'h8000_0000_0000_0000, 64'd2, 1'b1, ac); drain();
    issue(64'd7, -64'sd3, 1'b1, ac); drain();
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, ac); drain();
    chk("min_squared_hi", y_hi1, 64'h4000_0000_0000_0000);
    issue(64'd0, -64'sd5, 1'b1, ac); drain();
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, ac); drain();

    // Backpressure: hold the result while inputs churn.
    out_ready = 1'b0;
    issue(64'h0123_4567_89AB_CDEF, -64'sd77, 1'b1, ac);
    wait_out1(ok);
    lo1 = y_lo1; hi1 = y_hi1; lo4 = y_lo4; hi4 = y_hi4;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_valid1 || !out_valid4 || in_ready1 || in_ready4) bad++;
      if (y_lo1 !== lo1 || y_hi1 !== hi1 || y_lo4 !== lo4 || y_hi4 !== hi4) bad++;
    end
    chk("backpressure_stable", 128'(bad), 128'd0);
    out_ready = 1'b1;
    hs = cyc + 1;
    issue(64'd1000, 64'd1001, 1'b0, ac);
    chk("accept_after_handshake", 128'(ac), 128'(hs + 1));
    drain();

    // Reset in the middle of CALC.
    issue(64'hDEAD_BEEF_0000_1111, 64'h7777_8888_9999_AAAA, 1'b0, ac);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midop_in_ready", in_ready1, 1'b1);
    chk("midop_out_valid", out_valid1, 1'b0);
    chk("midop_y", {y_hi1, y_lo1}, 128'd0);
    q1.delete(); q4.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(64'd12, 64'd12, 1'b0, ac);
    wait_out1(ok);
    chk("after_reset_12x12", y_lo1, 64'd144);
    drain();

    // Random operands, mixed signedness and magnitude classes.
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = ra >> $urandom_range(1, 63);
        1: rb = -(rb >> $urandom_range(1, 63));
        2: ra = 64'h8000_0000_0000_0000;
        3: rb = '0;
        default: ;
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), ac);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
